// File: rtl/hack_rom_loader_if.sv
// Bus between the Hack instruction-side loader and its user: cpu fetch
// port, program byte stream and load status.
interface hack_rom_loader_if;
    logic [14:0] pc;
    logic [15:0] instruction;
    logic        cpu_reset;
    logic        load_start;
    logic [15:0] load_len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        busy;
    logic        done;
    logic [15:0] words_loaded;

    // Loader side.
    modport slave (
        input  pc, load_start, load_len, rx_data, rx_valid,
        output instruction, cpu_reset, rx_ready, busy, done, words_loaded
    );

    // CPU / host side.
    modport master (
        output pc, load_start, load_len, rx_data, rx_valid,
        input  instruction, cpu_reset, rx_ready, busy, done, words_loaded
    );
endinterface

// File: rtl/hack_rom_loader.sv
// Hack instruction ROM with a byte-stream program loader. Serves cpu
// fetches combinationally, holds the cpu in reset while a program is being
// written, and releases it a few cycles after the last word lands.
module hack_rom_loader #(
    parameter int ADDR_WIDTH  = 15,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    hack_rom_loader_if.slave   bus
);

    localparam int DEPTH    = 2 ** ADDR_WIDTH;
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_EFF + 1);

    typedef enum logic [1:0] {
        S_HOLD,  // cpu held in reset, counting down
        S_RUN,   // cpu running
        S_HIGH,  // waiting for the high byte of a word
        S_LOW    // waiting for the low byte of a word
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [15:0]             len_q, len_d;
    logic [15:0]             wl_q, wl_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              hi_q, hi_d;
    logic                    done_q, done_d;
    logic                    rom_we;
    logic                    loading;
    logic                    start_ok;
    logic [15:0]             wl_inc;

    logic [15:0]             rom [DEPTH];

    // Decoded straight from the state flop, so rx_ready never depends on rx_valid.
    assign loading = (state_q == S_HIGH) || (state_q == S_LOW);
    assign start_ok = bus.load_start && (bus.load_len != 16'd0) &&
                      ((state_q == S_HOLD) || (state_q == S_RUN));
    assign wl_inc  = wl_q + 16'd1;

    // Next-state and datapath update for the load sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        wl_d    = wl_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        done_d  = 1'b0;
        rom_we  = 1'b0;

        unique case (state_q)
            S_HOLD: begin
                if (start_ok) begin
                    state_d = S_HIGH;
                    len_d   = bus.load_len;
                    addr_d  = '0;
                    wl_d    = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (start_ok) begin
                    state_d = S_HIGH;
                    len_d   = bus.load_len;
                    addr_d  = '0;
                    wl_d    = '0;
                end
            end
            S_HIGH: begin
                if (bus.rx_valid) begin
                    hi_d    = bus.rx_data;
                    state_d = S_LOW;
                end
            end
            S_LOW: begin
                if (bus.rx_valid) begin
                    rom_we = ~reset;
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    wl_d   = wl_inc;
                    if (wl_inc == len_q) begin
                        done_d  = 1'b1;
                        state_d = S_HOLD;
                        cnt_d   = CNT_W'(HOLD_EFF);
                    end else begin
                        state_d = S_HIGH;
                    end
                end
            end
            default: state_d = S_HOLD;
        endcase
    end

    // Sequencer state registers with synchronous reset; a reset mid-load aborts it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= S_HOLD;
            cnt_q   <= CNT_W'(HOLD_EFF);
            len_q   <= '0;
            wl_q    <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            wl_q    <= wl_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            done_q  <= done_d;
        end
    end

    // Program store write port; contents survive reset so a partial load is kept.
    always_ff @(posedge clk) begin
        // NOTE: the ROM array has no reset on purpose; clearing it would need a sweep and lose the program.
        if (rom_we) begin
            rom[addr_q] <= {hi_q, bus.rx_data};
        end
    end

    assign bus.instruction  = rom[bus.pc[ADDR_WIDTH-1:0]];
    assign bus.cpu_reset    = (state_q != S_RUN);
    assign bus.rx_ready     = loading;
    assign bus.busy         = loading;
    assign bus.done         = done_q;
    assign bus.words_loaded = wl_q;

endmodule
